// File: rtl/mau_pkg.sv
// mau_pkg: shared types and constants for the memory access unit.
//   size_e  - request size encoding (2'b11 is illegal and has no member)
//   state_e - sequencer states
//   ERR_*   - response error codes
//   req_error() - classifies a request at accept time
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  // Checks run in priority order: size, then alignment, then range.
  function automatic logic [1:0] req_error(input logic [1:0]  size,
                                           input logic [31:0] addr,
                                           input int          addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    if (size == 2'b11)
      return ERR_SIZE;
    if ((size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00))
      return ERR_MISALIGN;
    if (hi != 32'd0)
      return ERR_RANGE;
    return ERR_OK;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// mau_lane: combinational byte-lane logic for the memory access unit.
//   word_i     - word read from memory
//   new_data_i - right-justified store data
//   addr_lo_i  - byte offset within the word (addr[1:0])
//   size_i     - access size (byte/half/word)
//   unsigned_i - zero-extend loads when 1, sign-extend when 0
//   load_o     - selected and extended load value
//   merged_o   - word_i with the addressed lane replaced by new_data_i
module mau_lane
  import mau_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] new_data_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: little-endian lane select, then extend.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front,
    // so no path through the case statements can infer a latch.
    byte_sel = word_i[7:0];
    load_o   = word_i;
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Store path: overwrite only the addressed lane of the old word.
  always_comb begin
    merged_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        case (addr_lo_i)
          2'd0:    merged_o[7:0]   = new_data_i[7:0];
          2'd1:    merged_o[15:8]  = new_data_i[7:0];
          2'd2:    merged_o[23:16] = new_data_i[7:0];
          default: merged_o[31:24] = new_data_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo_i[1]) merged_o[31:16] = new_data_i[15:0];
        else              merged_o[15:0]  = new_data_i[15:0];
      end
      default: merged_o = new_data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the MEM stage and a
// word-wide data memory of 2^ADDR_W words. One transaction at a time.
//   req_*   - request handshake and fields from the pipeline
//   resp_*  - response handshake, load data and error code
//   mem_*   - word address, write data, read/write strobes, read data
// Sub-word stores are done as read-modify-write since the memory only
// writes whole words.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  // Address bits above the memory range only feed the range check,
  // which is resolved at accept, so they are not kept.
  logic [ADDR_W+1:0]   addr_q, addr_d;
  // Holds store data, then the merged word after the read of an RMW.
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;

  logic [1:0]          req_err;
  logic [31:0]         lane_load;
  logic [31:0]         lane_merged;

  assign req_err = req_error(req_size, req_addr, ADDR_W);

  mau_lane u_lane (
    .word_i     (mem_rdata),
    .new_data_i (wdata_q),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .load_o     (lane_load),
    .merged_o   (lane_merged)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err != ERR_OK)                 state_d = RESP;
          else if (req_we && req_size == SZ_WORD) state_d = WRITE;
          else                                   state_d = READ;
        end
      end
      READ: begin
        if (we_q) begin
          wdata_d = lane_merged;
          state_d = WRITE;
        end else begin
          rdata_d = lane_load;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register, including the latched request fields, is cleared
  // by the asynchronous reset so the unit restarts from a known state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      // NOTE: non-blocking assignments here so all state updates together
      // at the clock edge, independent of statement order.
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset drops mem_wr immediately and an interrupted store never writes.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_rd     = (state_q == READ);
  assign mem_wr     = (state_q == WRITE);
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_wdata  = mem_wr ? wdata_q : '0;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid ? err_q : ERR_OK;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by
// random transactions, checked against an arithmetic reference model and
// a behavioural 32-word memory.
module tb_mem_access_unit;

  localparam int ADDR_W = 5;
  localparam int NWORDS = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_ready;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_rd, mem_wr;

  logic [31:0] mem     [NWORDS] = '{default: '0};
  logic [31:0] ref_mem [NWORDS] = '{default: '0};

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic logic [1:0] ref_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 2'd3;
    if ((size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)) return 2'd1;
    if (addr >= 32'(4 * NWORDS)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [31:0] addr);
    int unsigned bits, v;
    bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    if (bits == 32) return word;
    v = (word >> (8 * (addr % 4))) % (32'd1 << bits);
    if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] mask;
    int unsigned sh;
    mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh   = 8 * (addr % 4);
    return (old & ~(mask << sh)) | ((nw & mask) << sh);
  endfunction

  // ---- one full transaction, checked end to end ----
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, input string tag, output logic [31:0] got);
    logic [1:0]  e_err;
    logic [31:0] e_rdata, e_word, wd_seen;
    logic [4:0]  idx, wa_seen;
    int          e_lat, e_wr, e_rd, lat, wr_cyc, rd_cnt, both, busy_rdy;
    idx     = addr[6:2];
    e_err   = ref_err(size, addr);
    e_rdata = '0; e_word = '0; e_wr = 0; e_rd = 0;
    if (e_err != 2'd0) e_lat = 1;
    else if (we) begin
      e_word = ref_merge(ref_mem[idx], wdata, size, addr);
      e_lat  = (size == 2'd2) ? 2 : 3;
      e_wr   = e_lat - 1;
      e_rd   = (size == 2'd2) ? 0 : 1;
    end else begin
      e_rdata = ref_load(ref_mem[idx], size, uns, addr);
      e_lat   = 2;
      e_rd    = 1;
    end

    @(negedge clk);
    check({tag, " req_ready idle"}, req_ready, 1);
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; resp_ready = (hold == 0);
    @(negedge clk);
    // Fields must be ignored after the accept edge.
    req_valid = 0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

    lat = 0; wr_cyc = 0; rd_cnt = 0; both = 0; busy_rdy = 0; wd_seen = '0; wa_seen = '0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      if (resp_valid) lat = c;
      else begin
        if (mem_rd) rd_cnt++;
        if (mem_wr) begin wr_cyc = c; wd_seen = mem_wdata; wa_seen = mem_addr; end
        if (mem_rd && mem_wr) both = 1;
        if (req_ready) busy_rdy = 1;
        @(negedge clk);
      end
    end
    got = resp_rdata;
    check({tag, " latency"}, lat, e_lat);
    if (lat == 0) begin
      rst = 1; @(negedge clk); rst = 0;
      return;
    end
    check({tag, " rd cycles"}, rd_cnt, e_rd);
    check({tag, " wr cycle"}, wr_cyc, e_wr);
    check({tag, " rd&wr overlap"}, both, 0);
    check({tag, " req_ready busy"}, busy_rdy, 0);
    if (e_wr != 0) begin
      check({tag, " mem_wdata"}, wd_seen, e_word);
      check({tag, " mem_addr"}, wa_seen, idx);
    end
    check({tag, " rdata"}, resp_rdata, e_rdata);
    check({tag, " err"}, resp_err, e_err);
    check({tag, " req_ready resp"}, req_ready, 0);

    if (hold > 0) begin
      for (int h = 2; h <= hold; h++) begin
        @(negedge clk);
        check({tag, " hold valid"}, resp_valid, 1);
        check({tag, " hold rdata"}, resp_rdata, e_rdata);
        check({tag, " hold err"}, resp_err, e_err);
        check({tag, " hold req_ready"}, req_ready, 0);
        check({tag, " hold mem idle"}, {mem_rd, mem_wr}, 0);
      end
      @(negedge clk);
      check({tag, " last hold valid"}, resp_valid, 1);
      resp_ready = 1;
    end
    @(negedge clk);
    check({tag, " resp dropped"}, resp_valid, 0);
    check({tag, " back to idle"}, req_ready, 1);

    if (we && e_err == 2'd0) begin
      ref_mem[idx] = e_word;
      check({tag, " mem word"}, mem[idx], ref_mem[idx]);
    end
  endtask

  initial begin
    logic [31:0] got;
    rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; resp_ready = 1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst resp_valid", resp_valid, 0);
    check("rst mem strobes", {mem_rd, mem_wr}, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst resp_rdata", resp_rdata, 0);
    check("rst resp_err", resp_err, 0);
    rst = 0;
    @(negedge clk);
    check("post-rst req_ready", req_ready, 1);

    // Word store then load
    txn(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, "sw 0x10", got);
    check("sw 0x10 word", mem[4], 32'hDEADBEEF);
    txn(0, 2'd2, 0, 32'h10, 32'h0, 0, "lw 0x10", got);
    check("lw 0x10 const", got, 32'hDEADBEEF);

    // Byte store over existing word (RMW)
    txn(1, 2'd0, 0, 32'h11, 32'h0000005A, 0, "sb 0x11", got);
    txn(0, 2'd2, 0, 32'h10, 32'h0, 0, "lw 0x10 rmw", got);
    check("sb rmw const", got, 32'hDEAD5AEF);

    // Lane select and extension
    txn(1, 2'd2, 0, 32'h20, 32'h8077F0FF, 0, "sw 0x20", got);
    txn(0, 2'd0, 0, 32'h20, 32'h0, 0, "lb 0x20", got);
    check("lb const", got, 32'hFFFFFFFF);
    txn(0, 2'd0, 1, 32'h20, 32'h0, 0, "lbu 0x20", got);
    check("lbu const", got, 32'h000000FF);
    txn(0, 2'd1, 0, 32'h22, 32'h0, 0, "lh 0x22", got);
    check("lh const", got, 32'hFFFF8077);
    txn(0, 2'd1, 1, 32'h22, 32'h0, 0, "lhu 0x22", got);
    check("lhu const", got, 32'h00008077);
    txn(1, 2'd1, 0, 32'h22, 32'h0000A55A, 0, "sh 0x22", got);
    check("sh const", mem[8], 32'hA55AF0FF);

    // Error cases
    txn(0, 2'd1, 0, 32'h21, 32'h0, 0, "lh 0x21", got);
    txn(1, 2'd2, 0, 32'h82, 32'h12345678, 0, "sw 0x82", got);
    txn(0, 2'd2, 0, 32'h80, 32'h0, 0, "lw 0x80", got);
    txn(0, 2'd3, 0, 32'h10, 32'h0, 0, "size 11", got);
    txn(1, 2'd0, 0, 32'hF000_0010, 32'h11, 0, "sb far", got);

    // Back-pressure on the response
    txn(0, 2'd2, 0, 32'h20, 32'h0, 5, "lw hold5", got);

    // Reset during the WRITE cycle of a sub-word store
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'd0; req_unsigned = 0;
    req_addr = 32'h12; req_wdata = 32'h77; resp_ready = 1;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    check("rst-mid in WRITE", mem_wr, 1);
    #2 rst = 1;
    #1;
    check("rst-mid mem_wr drop", mem_wr, 0);
    check("rst-mid mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 0;
    check("rst-mid no write", mem[4], ref_mem[4]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst-mid no resp", resp_valid, 0);
      check("rst-mid req_ready", req_ready, 1);
    end
    txn(0, 2'd2, 0, 32'h10, 32'h0, 0, "lw after rst", got);

    // Random transactions
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * NWORDS - 1));
      txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
          $urandom_range(0, 2), "rand", got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
